tv_checker: RTL and testbench
=============================

TV_CHECKER -- requirements
Module: tv_checker

Interface
REQ-001 SHALL have parameter IN_W, default 3, DUT stimulus width.
REQ-002 SHALL have parameter OUT_W, default 1, DUT response width.
REQ-003 SHALL have parameter DEPTH, default 256, vector memory entries; AW = clog2(DEPTH).
REQ-004 SHALL have parameter SETTLE_CYC, default 1, range 1..15, cycles between stimulus drive and response sample.
REQ-005 SHALL have ports in this order:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- load_en  in  1  write one vector entry.
- load_addr  in  AW  entry index.
- load_data  in  VW  {stim, expected[, mask]}; VW = IN_W+OUT_W, or IN_W+2*OUT_W with mask.
- load_last  in  1  marks entry as final vector.
- start  in  1  one-cycle run request.
- abort  in  1  terminate run.
- dut_in  out  IN_W  registered stimulus.
- dut_out  in  OUT_W  DUT response.
- busy  out  1  run in progress.
- done  out  1  run finished; held until next start.
- pass  out  1  done with zero errors and no abort.
- vec_count  out  AW+1  vectors checked this run.
- err_count  out  16  mismatches, saturating.
- err_valid  out  1  one-cycle mismatch pulse.
- err_addr  out  AW  index of mismatching vector.
- err_got  out  OUT_W  sampled dut_out at mismatch.

Function
REQ-006 SHALL implement FSM IDLE, FETCH, SETTLE, CHECK, DONE.
REQ-007 IDLE/DONE + start: clear vec_count, err_count, pass, done; index=0; go FETCH.
REQ-008 FETCH: drive dut_in <= stim[index]; latch expected/mask/last; go SETTLE.
REQ-009 SETTLE SHALL last SETTLE_CYC cycles, then CHECK; dut_in held constant throughout.
REQ-010 CHECK: compare dut_out with expected (masked bits excluded); vec_count+1; mismatch -> err_valid pulse, err_addr=index, err_got=dut_out, err_count+1 saturating at 16'hFFFF.
REQ-011 Each vector SHALL occupy exactly SETTLE_CYC+2 cycles.
REQ-012 CHECK exit: last flag set or index==DEPTH-1 -> DONE; else index+1 -> FETCH.
REQ-013 No entry flagged last SHALL run all DEPTH vectors, no wrap.
REQ-014 DONE: done=1, busy=0, pass=(err_count==0); outputs held until start.
REQ-015 abort in FETCH/SETTLE/CHECK SHALL go DONE next cycle, pass=0, the current vector uncounted; abort beats start same cycle.
REQ-016 start while busy SHALL be ignored.
REQ-017 load_en while busy SHALL be ignored; in IDLE/DONE writes memory next edge.
REQ-018 busy=1 in FETCH, SETTLE, CHECK only.

Reset
REQ-019 reset==0 at rising edge SHALL force IDLE, dut_in=0, busy=0, done=0, pass=0, vec_count=0, err_count=0, err_valid=0, err_addr=0, err_got=0.
REQ-020 Reset mid-run SHALL abandon the run without done; memory contents retained.

Configuration
REQ-021 Macro TV_CHECKER_MASK_EN defined: VW=IN_W+2*OUT_W; mask bit=1 makes that output bit don't-care.
REQ-022 Macro undefined: VW=IN_W+OUT_W; all output bits compared exactly; no mask storage.

Verification
REQ-023 Bench SHALL cover, defaults unless stated:
- 4 vectors, last on entry 3, DUT correct -> done after 12 cycles, pass=1, vec_count=4, err_count=0.
- Vector 2 expected wrong -> one err_valid, err_addr=2, err_count=1, pass=0.
- abort during SETTLE of vector 1 -> done next cycle, pass=0, vec_count=1.
- DEPTH=4, no last flag -> stops after 4 vectors; start mid-run ignored.
- Reset mid-run then start -> counters restart from 0.
- MASK_EN, mask=1, expected=0, dut_out=1 -> no error, pass=1.

Source files
------------

// File: rtl/tv_checker.sv
// Test-vector sequencer: replays stored stimulus into a DUT, compares its response.
// Define TV_CHECKER_MASK_EN to store a per-vector don't-care mask alongside expected.
module tv_checker #(
   parameter int unsigned IN_W       = 3,
   parameter int unsigned OUT_W      = 1,
   parameter int unsigned DEPTH      = 256,
   parameter int unsigned SETTLE_CYC = 1,
   localparam int unsigned AW        = $clog2(DEPTH),
`ifdef TV_CHECKER_MASK_EN
   localparam int unsigned VW        = IN_W + 2 * OUT_W
`else
   localparam int unsigned VW        = IN_W + OUT_W
`endif
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_en,
   input  logic [AW-1:0]    load_addr,
   input  logic [VW-1:0]    load_data,
   input  logic             load_last,
   input  logic             start,
   input  logic             abort,
   output logic [IN_W-1:0]  dut_in,
   input  logic [OUT_W-1:0] dut_out,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [AW:0]      vec_count,
   output logic [15:0]      err_count,
   output logic             err_valid,
   output logic [AW-1:0]    err_addr,
   output logic [OUT_W-1:0] err_got
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_SETTLE,
      S_CHECK,
      S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [AW-1:0]    index_q, index_d;
   logic [3:0]       settle_cnt_q, settle_cnt_d;
   logic [IN_W-1:0]  dut_in_q, dut_in_d;
   logic [OUT_W-1:0] exp_q, exp_d;
   logic             last_q, last_d;
   logic             pass_q, pass_d;
   logic [AW:0]      vec_count_q, vec_count_d;
   logic [15:0]      err_count_q, err_count_d;
   logic             err_valid_q, err_valid_d;
   logic [AW-1:0]    err_addr_q, err_addr_d;
   logic [OUT_W-1:0] err_got_q, err_got_d;

   // Entry layout: {last, stim, expected[, mask]}
   logic [VW:0]      mem_q [DEPTH];
   logic [VW:0]      entry;
   logic             mem_we;
   logic [OUT_W-1:0] care;
   logic             mismatch;

`ifdef TV_CHECKER_MASK_EN
   logic [OUT_W-1:0] mask_q, mask_d;
`endif

   assign entry = mem_q[index_q];

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[load_addr] <= {load_last, load_data};
      end
   end

   always_comb begin
`ifdef TV_CHECKER_MASK_EN
      care = ~mask_q;
`else
      care = '1;
`endif
      mismatch = |((dut_out ^ exp_q) & care);
   end

   always_comb begin
      state_d      = state_q;
      index_d      = index_q;
      settle_cnt_d = settle_cnt_q;
      dut_in_d     = dut_in_q;
      exp_d        = exp_q;
      last_d       = last_q;
      pass_d       = pass_q;
      vec_count_d  = vec_count_q;
      err_count_d  = err_count_q;
      err_valid_d  = 1'b0;
      err_addr_d   = err_addr_q;
      err_got_d    = err_got_q;
`ifdef TV_CHECKER_MASK_EN
      mask_d       = mask_q;
`endif
      mem_we       = 1'b0;

      case (state_q)
         S_IDLE, S_DONE: begin
            mem_we = load_en;
            if (start && !abort) begin
               vec_count_d = '0;
               err_count_d = '0;
               pass_d      = 1'b0;
               index_d     = '0;
               state_d     = S_FETCH;
            end
         end
         S_FETCH: begin
            if (abort) begin
               pass_d  = 1'b0;
               state_d = S_DONE;
            end else begin
`ifdef TV_CHECKER_MASK_EN
               dut_in_d = entry[VW-1:2*OUT_W];
               exp_d    = entry[2*OUT_W-1:OUT_W];
               mask_d   = entry[OUT_W-1:0];
`else
               dut_in_d = entry[VW-1:OUT_W];
               exp_d    = entry[OUT_W-1:0];
`endif
               last_d       = entry[VW];
               settle_cnt_d = '0;
               state_d      = S_SETTLE;
            end
         end
         S_SETTLE: begin
            if (abort) begin
               pass_d  = 1'b0;
               state_d = S_DONE;
            end else if (settle_cnt_q == 4'(SETTLE_CYC - 1)) begin
               state_d = S_CHECK;
            end else begin
               settle_cnt_d = settle_cnt_q + 4'd1;
            end
         end
         S_CHECK: begin
            if (abort) begin
               pass_d  = 1'b0;
               state_d = S_DONE;
            end else begin
               vec_count_d = vec_count_q + (AW+1)'(1);
               if (mismatch) begin
                  err_valid_d = 1'b1;
                  err_addr_d  = index_q;
                  err_got_d   = dut_out;
                  if (err_count_q != '1) begin
                     err_count_d = err_count_q + 16'd1;
                  end
               end
               if (last_q || (index_q == AW'(DEPTH - 1))) begin
                  pass_d  = (err_count_d == '0);
                  state_d = S_DONE;
               end else begin
                  index_d = index_q + AW'(1);
                  state_d = S_FETCH;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         index_q      <= '0;
         settle_cnt_q <= '0;
         dut_in_q     <= '0;
         exp_q        <= '0;
         last_q       <= 1'b0;
         pass_q       <= 1'b0;
         vec_count_q  <= '0;
         err_count_q  <= '0;
         err_valid_q  <= 1'b0;
         err_addr_q   <= '0;
         err_got_q    <= '0;
      end else begin
         state_q      <= state_d;
         index_q      <= index_d;
         settle_cnt_q <= settle_cnt_d;
         dut_in_q     <= dut_in_d;
         exp_q        <= exp_d;
         last_q       <= last_d;
         pass_q       <= pass_d;
         vec_count_q  <= vec_count_d;
         err_count_q  <= err_count_d;
         err_valid_q  <= err_valid_d;
         err_addr_q   <= err_addr_d;
         err_got_q    <= err_got_d;
      end
   end

`ifdef TV_CHECKER_MASK_EN
   always_ff @(posedge clk) begin
      if (!reset) begin
         mask_q <= '0;
      end else begin
         mask_q <= mask_d;
      end
   end
`endif

   assign dut_in    = dut_in_q;
   assign busy      = (state_q == S_FETCH) || (state_q == S_SETTLE) || (state_q == S_CHECK);
   assign done      = (state_q == S_DONE);
   assign pass      = pass_q;
   assign vec_count = vec_count_q;
   assign err_count = err_count_q;
   assign err_valid = err_valid_q;
   assign err_addr  = err_addr_q;
   assign err_got   = err_got_q;

endmodule

// File: tb/tb_tv_checker.sv
// Directed bench for tv_checker: a parity circuit stands in for the DUT under test.
module tb_tv_checker;

`ifdef TV_CHECKER_MASK_EN
   localparam int unsigned VW = 5;
`else
   localparam int unsigned VW = 4;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic          load_en;
   logic [7:0]    load_addr;
   logic [VW-1:0] load_data;
   logic          load_last;
   logic          start;
   logic          abort;
   logic [2:0]    dut_in;
   logic          dut_out;
   logic          busy, done, pass, err_valid, err_got;
   logic [8:0]    vec_count;
   logic [15:0]   err_count;
   logic [7:0]    err_addr;

   logic          start4;
   logic [2:0]    dut_in4;
   logic          dut_out4;
   logic          busy4, done4, pass4, err_valid4, err_got4;
   logic [2:0]    vec_count4;
   logic [15:0]   err_count4;
   logic [1:0]    err_addr4;

   int n_chk  = 0;
   int n_pass = 0;
   int n_fail = 0;
   int err_pulses;
   logic pulse_clr;

   always #5 clk = ~clk;

   assign dut_out  = ^dut_in;
   assign dut_out4 = ^dut_in4;

   tv_checker #(.IN_W(3), .OUT_W(1), .DEPTH(256), .SETTLE_CYC(1)) u_dut (
      .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
      .load_data(load_data), .load_last(load_last), .start(start), .abort(abort),
      .dut_in(dut_in), .dut_out(dut_out), .busy(busy), .done(done), .pass(pass),
      .vec_count(vec_count), .err_count(err_count), .err_valid(err_valid),
      .err_addr(err_addr), .err_got(err_got)
   );

   tv_checker #(.IN_W(3), .OUT_W(1), .DEPTH(4), .SETTLE_CYC(1)) u_dut4 (
      .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr[1:0]),
      .load_data(load_data), .load_last(1'b0), .start(start4), .abort(1'b0),
      .dut_in(dut_in4), .dut_out(dut_out4), .busy(busy4), .done(done4), .pass(pass4),
      .vec_count(vec_count4), .err_count(err_count4), .err_valid(err_valid4),
      .err_addr(err_addr4), .err_got(err_got4)
   );

   always @(negedge clk) begin
      if (pulse_clr) err_pulses <= 0;
      else if (err_valid === 1'b1) err_pulses <= err_pulses + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic load(input logic [7:0] addr, input logic [2:0] stim, input logic exp,
                       input logic mask, input logic last);
      load_en   = 1'b1;
      load_addr = addr;
`ifdef TV_CHECKER_MASK_EN
      load_data = {stim, exp, mask};
`else
      load_data = {stim, exp};
      if (mask) load_data = {stim, exp};
`endif
      load_last = last;
      tick();
      load_en   = 1'b0;
      load_last = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 100; i++) begin
         if (done === 1'b1) break;
         tick();
      end
      chk("done_reached", 32'(done), 32'd1);
   endtask

   initial begin
      reset = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0; load_last = 1'b0;
      start = 1'b0; abort = 1'b0; start4 = 1'b0; pulse_clr = 1'b1;
      tick(); tick();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_pass", 32'(pass), 32'd0);
      chk("rst_vec_count", 32'(vec_count), 32'd0);
      chk("rst_err_count", 32'(err_count), 32'd0);
      chk("rst_err_valid", 32'(err_valid), 32'd0);
      chk("rst_dut_in", 32'(dut_in), 32'd0);
      reset = 1'b1;

      // parity responses: stim 1->1, 2->1, 3->0, 7->1
      load(8'd0, 3'd1, 1'b1, 1'b0, 1'b0);
      load(8'd1, 3'd2, 1'b1, 1'b0, 1'b0);
      load(8'd2, 3'd3, 1'b0, 1'b0, 1'b0);
      load(8'd3, 3'd7, 1'b1, 1'b0, 1'b1);

      // clean 4-vector run: done exactly 12 edges after the start edge
      pulse_start();
      pulse_clr = 1'b0;
      chk("t1_busy_fetch", 32'(busy), 32'd1);
      tick();
      chk("t1_dut_in_v0", 32'(dut_in), 32'd1);
      repeat (10) tick();
      chk("t1_not_done_e11", 32'(done), 32'd0);
      tick();
      chk("t1_done_e12", 32'(done), 32'd1);
      chk("t1_busy_off", 32'(busy), 32'd0);
      chk("t1_pass", 32'(pass), 32'd1);
      chk("t1_vec_count", 32'(vec_count), 32'd4);
      chk("t1_err_count", 32'(err_count), 32'd0);
      chk("t1_err_pulses", 32'(err_pulses), 32'd0);
      repeat (3) tick();
      chk("t1_done_held", 32'(done), 32'd1);

      // wrong expectation on entry 2
      load(8'd2, 3'd3, 1'b1, 1'b0, 1'b0);
      pulse_clr = 1'b1;
      pulse_start();
      pulse_clr = 1'b0;
      wait_done();
      chk("t2_err_pulses", 32'(err_pulses), 32'd1);
      chk("t2_err_addr", 32'(err_addr), 32'd2);
      chk("t2_err_got", 32'(err_got), 32'd0);
      chk("t2_err_count", 32'(err_count), 32'd1);
      chk("t2_pass", 32'(pass), 32'd0);
      chk("t2_vec_count", 32'(vec_count), 32'd4);
      load(8'd2, 3'd3, 1'b0, 1'b0, 1'b0);

      // abort during SETTLE of vector 1, with a competing start
      pulse_start();
      repeat (4) tick();
      chk("t3_dut_in_v1", 32'(dut_in), 32'd2);
      chk("t3_busy", 32'(busy), 32'd1);
      abort = 1'b1;
      start = 1'b1;
      tick();
      abort = 1'b0;
      start = 1'b0;
      chk("t3_done", 32'(done), 32'd1);
      chk("t3_pass", 32'(pass), 32'd0);
      chk("t3_vec_count", 32'(vec_count), 32'd1);
      tick();
      chk("t3_stay_done", 32'(done), 32'd1);

      // DEPTH=4 instance, no last flag, restart attempt mid-run
      start4 = 1'b1;
      tick();
      start4 = 1'b0;
      repeat (4) tick();
      start4 = 1'b1;
      tick();
      start4 = 1'b0;
      repeat (6) tick();
      chk("t4_busy_e11", 32'(busy4), 32'd1);
      chk("t4_not_done_e11", 32'(done4), 32'd0);
      tick();
      chk("t4_done_e12", 32'(done4), 32'd1);
      chk("t4_vec_count", 32'(vec_count4), 32'd4);
      chk("t4_err_count", 32'(err_count4), 32'd0);
      chk("t4_pass", 32'(pass4), 32'd1);

      // reset mid-run, memory retained
      pulse_start();
      repeat (5) tick();
      chk("t5_vec_count_mid", 32'(vec_count), 32'd1);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      chk("t5_busy_rst", 32'(busy), 32'd0);
      chk("t5_done_rst", 32'(done), 32'd0);
      chk("t5_vec_count_rst", 32'(vec_count), 32'd0);
      chk("t5_dut_in_rst", 32'(dut_in), 32'd0);
      pulse_start();
      wait_done();
      chk("t5_vec_count", 32'(vec_count), 32'd4);
      chk("t5_pass", 32'(pass), 32'd1);
      chk("t5_err_count", 32'(err_count), 32'd0);

`ifdef TV_CHECKER_MASK_EN
      // stim 1 gives response 1; expected 0 but masked
      load(8'd0, 3'd1, 1'b0, 1'b1, 1'b1);
      pulse_start();
      wait_done();
      chk("t6_pass", 32'(pass), 32'd1);
      chk("t6_err_count", 32'(err_count), 32'd0);
      chk("t6_vec_count", 32'(vec_count), 32'd1);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
